// File: rtl/rom_bus_scheduler.sv
// rom_bus_scheduler: CPU bus-cycle sequencer, ROM bank latch and SDRAM ROM port arbiter
module rom_bus_scheduler #(
  parameter int FIXED_WAIT  = 2,
  parameter int ROM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_cyc,
  input  logic        cpu_rom_memrq,
  input  logic [19:0] cpu_rom_addr,
  output logic        cpu_ready,
  output logic [15:0] cpu_rom_data,
  input  logic        bank_wr,
  input  logic [3:0]  bank_din,
  output logic [3:0]  bank_select,
  input  logic        aux_req,
  input  logic [19:0] aux_addr,
  output logic        aux_ack,
  output logic [15:0] aux_data,
  output logic        rom_req,
  output logic [19:0] rom_addr,
  input  logic        rom_ack,
  input  logic [15:0] rom_data,
  output logic        rom_timeout
);
  typedef enum logic [2:0] {IDLE, WAITST, ROM_CPU, ROM_AUX, DONE} state_t;
  state_t state, state_nxt;
  logic        pend, pend_rom, aux_starve, ack_q, go_aux, go_cpu, tmo, rom_done, enter_rom;
  logic [19:0] pend_addr;
  logic [15:0] data_q, rdata;
  logic [7:0]  wcnt, tcnt;
  // a finished cycle reads as ready while in DONE, so the CPU may start the next one there
  assign cpu_ready = !pend || state == DONE;
  // grant decisions, ROM completion and next state
  always_comb begin
    go_aux = state == IDLE && aux_req && !aux_ack && (aux_starve || !(pend || cpu_cyc));
    go_cpu = state == IDLE && pend && !go_aux;
    enter_rom = go_aux || (go_cpu && pend_rom);
    tmo = rom_req && !rom_ack && tcnt == 8'(ROM_TIMEOUT);
    rom_done = ack_q || tmo;
    rdata = tmo ? 16'hFFFF : data_q;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = go_aux ? ROM_AUX : !go_cpu ? IDLE : pend_rom ? ROM_CPU : FIXED_WAIT == 0 ? DONE : WAITST;
      WAITST:  state_nxt = wcnt == 8'd0 ? DONE : WAITST;
      ROM_CPU: state_nxt = rom_done ? DONE : ROM_CPU;
      ROM_AUX: state_nxt = rom_done ? IDLE : ROM_AUX;
      default: state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  // latch one CPU cycle; further cpu_cyc pulses are ignored until it completes
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pend      <= 1'b0;
      pend_rom  <= 1'b0;
      pend_addr <= '0;
    end else if (cpu_cyc && cpu_ready) begin
      pend      <= 1'b1;
      pend_rom  <= cpu_rom_memrq;
      pend_addr <= cpu_rom_addr;
    end else if (state == DONE) pend <= 1'b0;
  // bank latch is independent of the sequencer
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) bank_select <= '0;
    else if (bank_wr) bank_select <= bank_din;
  // SDRAM handshake, timeout, data capture, wait counter and aux fairness
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rom_req      <= 1'b0;
      rom_addr     <= '0;
      tcnt         <= '0;
      wcnt         <= '0;
      ack_q        <= 1'b0;
      data_q       <= '0;
      aux_ack      <= 1'b0;
      aux_data     <= '0;
      cpu_rom_data <= '0;
      rom_timeout  <= 1'b0;
      aux_starve   <= 1'b0;
    end else begin
      ack_q   <= rom_ack && rom_req;
      data_q  <= rom_data;
      aux_ack <= state == ROM_AUX && rom_done;
      if (enter_rom) begin
        rom_req  <= 1'b1;
        rom_addr <= go_aux ? aux_addr : pend_addr;
        tcnt     <= '0;
      end else if (rom_req) begin
        rom_req <= !(rom_ack || tmo);
        tcnt    <= tcnt + 8'd1;
      end
      if (tmo) rom_timeout <= 1'b1;
      if (state == ROM_CPU && rom_done) cpu_rom_data <= rdata;
      if (state == ROM_AUX && rom_done) aux_data <= rdata;
      wcnt <= go_cpu ? 8'(FIXED_WAIT > 0 ? FIXED_WAIT - 1 : 0) : (state == WAITST && wcnt != 8'd0) ? wcnt - 8'd1 : wcnt;
      aux_starve <= go_aux ? 1'b0 : (go_cpu && pend_rom && aux_req) ? 1'b1 : aux_starve;
    end
endmodule

// File: tb/tb_rom_bus_scheduler.sv
// tb_rom_bus_scheduler: directed self-checking bench for rom_bus_scheduler
module tb_rom_bus_scheduler;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        cpu_cyc = 1'b0, cpu_rom_memrq = 1'b0, bank_wr = 1'b0, aux_req = 1'b0, rom_ack = 1'b0;
  logic [19:0] cpu_rom_addr = '0, aux_addr = '0;
  logic [3:0]  bank_din = '0;
  logic [15:0] rom_data = '0;
  logic        cpu_ready, aux_ack, rom_req, rom_timeout;
  logic [15:0] cpu_rom_data, aux_data;
  logic [3:0]  bank_select;
  logic [19:0] rom_addr;
  int total = 0, bad = 0, n;

  rom_bus_scheduler dut (
    .clk(clk), .reset_n(reset_n), .cpu_cyc(cpu_cyc), .cpu_rom_memrq(cpu_rom_memrq),
    .cpu_rom_addr(cpu_rom_addr), .cpu_ready(cpu_ready), .cpu_rom_data(cpu_rom_data),
    .bank_wr(bank_wr), .bank_din(bank_din), .bank_select(bank_select), .aux_req(aux_req),
    .aux_addr(aux_addr), .aux_ack(aux_ack), .aux_data(aux_data), .rom_req(rom_req),
    .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data), .rom_timeout(rom_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_go(input logic rom, input logic [19:0] a);
    cpu_cyc = 1'b1;
    cpu_rom_memrq = rom;
    cpu_rom_addr = a;
    tick();
    cpu_cyc = 1'b0;
  endtask

  task automatic wait_ready(input int lim, output int cnt);
    cnt = 0;
    while (!cpu_ready && cnt < lim) begin
      tick();
      cnt++;
    end
  endtask

  task automatic serve(input string tag, input logic [19:0] a, input logic [15:0] d, input int dly);
    int k = 0;
    logic held = 1'b1;
    while (!rom_req && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_req"}, rom_req, 1);
    chk({tag, "_addr"}, rom_addr, a);
    repeat (dly) begin
      tick();
      held &= rom_req;
    end
    rom_ack = 1'b1;
    rom_data = d;
    tick();
    rom_ack = 1'b0;
    rom_data = '0;
    chk({tag, "_held_drop"}, {held, rom_req}, 2'b10);
  endtask

  initial begin
    #3;
    chk("rst_outs", {cpu_ready, aux_ack, rom_req, rom_timeout, bank_select}, 8'h80);
    chk("rst_data", {cpu_rom_data, aux_data}, 0);
    chk("rst_addr", rom_addr, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (7) tick();
    cpu_go(1'b0, 20'h0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("nonrom_ready_%0d", k), cpu_ready, k == 4);
      tick();
    end
    chk("nonrom_idle_ready", cpu_ready, 1);
    bank_wr = 1'b1;
    bank_din = 4'h5;
    chk("bank_before", bank_select, 0);
    tick();
    bank_wr = 1'b0;
    chk("bank_after", bank_select, 5);
    cpu_go(1'b1, 20'h12340);
    serve("beef", 20'h12340, 16'hBEEF, 7);
    chk("beef_ready_a1", cpu_ready, 0);
    tick();
    chk("beef_ready_a2", cpu_ready, 1);
    chk("beef_data", cpu_rom_data, 16'hBEEF);
    tick();
    aux_req = 1'b1;
    aux_addr = 20'h00AAA;
    cpu_go(1'b1, 20'h00100);
    serve("b2b_cpu1", 20'h00100, 16'h1111, 0);
    wait_ready(20, n);
    chk("b2b_cpu1_data", {cpu_ready, cpu_rom_data}, {1'b1, 16'h1111});
    cpu_go(1'b1, 20'h00200);
    serve("b2b_aux", 20'h00AAA, 16'h2222, 1);
    n = 0;
    while (!aux_ack && n < 20) begin
      tick();
      n++;
    end
    chk("b2b_aux_ack", {aux_ack, aux_data}, {1'b1, 16'h2222});
    chk("b2b_cpu2_waiting", cpu_ready, 0);
    aux_req = 1'b0;
    tick();
    chk("aux_ack_pulse", aux_ack, 0);
    serve("b2b_cpu2", 20'h00200, 16'h3333, 2);
    wait_ready(20, n);
    chk("b2b_cpu2_data", {cpu_ready, cpu_rom_data}, {1'b1, 16'h3333});
    tick();
    cpu_go(1'b1, 20'h00300);
    wait_ready(400, n);
    chk("tmo_cycles", n, 257);
    chk("tmo_data", cpu_rom_data, 16'hFFFF);
    chk("tmo_flag_req", {rom_timeout, rom_req}, 2'b10);
    rom_ack = 1'b1;
    rom_data = 16'h1234;
    tick();
    rom_ack = 1'b0;
    chk("late_ack_data", cpu_rom_data, 16'hFFFF);
    chk("late_ack_state", {cpu_ready, rom_req, aux_ack}, 3'b100);
    cpu_go(1'b1, 20'h00400);
    serve("after_tmo", 20'h00400, 16'h5555, 3);
    wait_ready(20, n);
    chk("after_tmo_data", {cpu_ready, cpu_rom_data, rom_timeout}, {1'b1, 16'h5555, 1'b1});
    tick();
    cpu_go(1'b1, 20'h00500);
    n = 0;
    while (!rom_req && n < 20) begin
      tick();
      n++;
    end
    bank_wr = 1'b1;
    bank_din = 4'hA;
    tick();
    bank_wr = 1'b0;
    chk("bank_midaccess", {bank_select, rom_addr}, {4'hA, 20'h00500});
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst", {rom_req, cpu_ready, bank_select, rom_timeout}, 7'b0100000);
    tick();
    reset_n = 1'b1;
    tick();
    cpu_go(1'b0, 20'h0);
    wait_ready(20, n);
    chk("post_rst_nonrom", n, 3);
    tick();
    cpu_go(1'b1, 20'h00600);
    serve("post_rst_rom", 20'h00600, 16'h6666, 1);
    wait_ready(20, n);
    chk("post_rst_rom_data", {cpu_ready, cpu_rom_data}, {1'b1, 16'h6666});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
